ro_freq_meter: RTL and testbench

Multi-channel gated frequency meter for the ring-oscillator entropy/PUF datapath. It counts rising edges on NUM_CH asynchronous oscillator inputs over a programmable window of system-clock cycles, then latches all channel counts simultaneously. It sits between the oscillator array and the response/entropy extraction logic, which starts a measurement and reads back per-channel counts.

---
 rtl/ro_freq_meter_pkg.sv | 21 ++
 rtl/ro_edge_sync.sv | 30 +++
 rtl/ro_freq_meter.sv | 113 +++++++++++
 tb/tb_ro_freq_meter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_freq_meter_pkg.sv
// Shared types and defaults for the ring-oscillator frequency meter.
// FSM states, parameter defaults and synchronizer depth floor.
package ro_freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    DONE
  } state_t;

  localparam int NUM_CH_DEF      = 8;
  localparam int CNT_W_DEF       = 16;
  localparam int GATE_W_DEF      = 20;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_MIN        = 2;

  function automatic int sync_depth(input int n);
    return (n < SYNC_MIN) ? SYNC_MIN : n;
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// One oscillator channel: multi-flop synchronizer plus rising-edge detect.
// Runs in every FSM state so the gate never opens on a stale edge.
module ro_edge_sync
  import ro_freq_meter_pkg::*;
#(
  parameter int STAGES = SYNC_MIN
)(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // shift the async input through the sync chain, keep last synced value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Multi-channel gated edge counter for the ring-oscillator array.
// Define FREQ_METER_SAT_EN for saturating counters with sticky sat flags.
module ro_freq_meter
  import ro_freq_meter_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int GATE_W      = GATE_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [GATE_W-1:0]       gate_cycles,
  input  logic [NUM_CH-1:0]       osc_in,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic [NUM_CH-1:0]       sat
);

  localparam int SYNC_N = sync_depth(SYNC_STAGES);

  state_t                       state_q, state_d;
  logic [GATE_W-1:0]            gate_q, gate_d;
  logic [NUM_CH-1:0][CNT_W-1:0] work_q, work_d;
  logic [NUM_CH-1:0][CNT_W-1:0] count_q;
  logic [NUM_CH-1:0]            satw_q, satw_d;
  logic [NUM_CH-1:0]            sat_q;
  logic [NUM_CH-1:0]            rise;
  logic                         latch;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ro_edge_sync #(
      .STAGES(SYNC_N)
    ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (osc_in[g]),
      .rise     (rise[g])
    );
  end

  // next state, gate countdown and per-channel counting
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    work_d  = work_q;
    satw_d  = satw_q;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d = '0;
          satw_d = '0;
          if (gate_cycles != '0) begin
            gate_d  = gate_cycles;
            state_d = GATE;
          end else begin
            state_d = DONE;
            latch   = 1'b1;
          end
        end
      end
      GATE: begin
        gate_d = gate_q - GATE_W'(1);
        for (int c = 0; c < NUM_CH; c++) begin
          if (rise[c]) begin
`ifdef FREQ_METER_SAT_EN
            if (&work_q[c]) satw_d[c] = 1'b1;
            else work_d[c] = work_q[c] + CNT_W'(1);
`else
            work_d[c] = work_q[c] + CNT_W'(1);
`endif
          end
        end
        if (gate_q == GATE_W'(1)) begin
          state_d = DONE;
          latch   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and counters; results latched on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gate_q  <= '0;
      work_q  <= '0;
      satw_q  <= '0;
      count_q <= '0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      work_q  <= work_d;
      satw_q  <= satw_d;
      if (latch) begin
        count_q <= work_d;
        sat_q   <= satw_d;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign count_out = count_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter with an expected-result queue.
// Honours FREQ_METER_SAT_EN for the narrow-counter instance.
module tb_ro_freq_meter;

  localparam int NCH = 8;
  localparam int CW  = 16;

  typedef struct {
    string              tag;
    logic [NCH-1:0][CW-1:0] cnt;
    logic [NCH-1:0]     tolv;
    int                 lat;
  } exp_t;

  typedef struct {
    string    tag;
    logic [3:0] c0;
    logic [1:0] sat;
  } exp4_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [19:0]       gate_cycles = '0;
  logic [NCH-1:0]    osc = '0;
  logic              busy, done;
  logic [NCH*CW-1:0] count_out;
  logic [NCH-1:0]    sat;

  logic              start4 = 1'b0;
  logic [19:0]       gate4 = '0;
  logic [1:0]        osc4 = '0;
  logic              busy4, done4;
  logic [7:0]        count4;
  logic [1:0]        sat4;

  int per [NCH];
  int ph  [NCH];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  exp_t  sbq [$];
  exp4_t q4 [$];

  ro_freq_meter dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .gate_cycles (gate_cycles),
    .osc_in      (osc),
    .busy        (busy),
    .done        (done),
    .count_out   (count_out),
    .sat         (sat)
  );

  ro_freq_meter #(
    .NUM_CH (2),
    .CNT_W  (4)
  ) dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start4),
    .gate_cycles (gate4),
    .osc_in      (osc4),
    .busy        (busy4),
    .done        (done4),
    .count_out   (count4),
    .sat         (sat4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // oscillators: toggle every per[c] 5ns ticks, offset from clock edges
  initial begin
    for (int c = 0; c < NCH; c++) begin
      per[c] = 0;
      ph[c]  = 0;
    end
    #2;
    forever begin
      #5;
      for (int c = 0; c < NCH; c++) begin
        if (per[c] == 0) ph[c] = 0;
        else begin
          ph[c]++;
          if (ph[c] >= per[c]) begin
            ph[c]  = 0;
            osc[c] = ~osc[c];
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void push_exp(input string tag, input int g);
    exp_t e;
    e.tag = tag;
    e.lat = g + 1;
    for (int c = 0; c < NCH; c++) begin
      if (g == 0 || per[c] == 0) begin
        e.cnt[c]  = '0;
        e.tolv[c] = 1'b0;
      end else begin
        e.cnt[c]  = CW'(g / per[c]);
        e.tolv[c] = 1'b1;
      end
    end
    sbq.push_back(e);
  endfunction

  task automatic measure(input int g, input bit poke);
    exp_t e;
    int cyc;
    int d;
    @(negedge clk);
    start = 1'b1;
    gate_cycles = 20'(g);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    if (g > 0) begin
      checks++;
      assert (busy === 1'b1) else begin
        errors++;
        $error("FAIL busy_gate: got %b want 1", busy);
      end
    end
    while (done !== 1'b1 && cyc < g + 20) begin
      @(negedge clk);
      cyc++;
      start = (poke && cyc == 5);
    end
    start = 1'b0;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL scoreboard: queue empty");
    end else begin
      e = sbq.pop_front();
      checks++;
      assert (done === 1'b1) else begin
        errors++;
        $error("FAIL %s done_timeout: got %b want 1", e.tag, done);
      end
      checks++;
      assert (cyc === e.lat) else begin
        errors++;
        $error("FAIL %s latency: got %0d want %0d", e.tag, cyc, e.lat);
      end
      for (int c = 0; c < NCH; c++) begin
        d = int'(count_out[c*CW +: CW]) - int'(e.cnt[c]);
        checks++;
        assert ((e.tolv[c] && d >= -1 && d <= 1) || (!e.tolv[c] && d == 0))
        else begin
          errors++;
          $error("FAIL %s ch%0d count: got %0d want %0d", e.tag, c,
                 count_out[c*CW +: CW], e.cnt[c]);
        end
      end
      checks++;
      assert (sat === '0) else begin
        errors++;
        $error("FAIL %s sat: got %b want 0", e.tag, sat);
      end
    end
    @(negedge clk);
    checks++;
    assert (done === 1'b0 && busy === 1'b0) else begin
      errors++;
      $error("FAIL idle_after_done: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic measure4(input int g);
    exp4_t e;
    int cyc;
    @(negedge clk);
    start4 = 1'b1;
    gate4 = 20'(g);
    @(negedge clk);
    start4 = 1'b0;
    cyc = 1;
    while (done4 !== 1'b1 && cyc < g + 20) begin
      @(negedge clk);
      cyc++;
    end
    if (q4.size() == 0) begin
      errors++;
      $error("FAIL scoreboard4: queue empty");
    end else begin
      e = q4.pop_front();
      checks++;
      assert (done4 === 1'b1 && cyc === g + 1) else begin
        errors++;
        $error("FAIL %s done4: got done=%b cyc=%0d want 1 %0d",
               e.tag, done4, cyc, g + 1);
      end
      checks++;
      assert (count4[3:0] === e.c0) else begin
        errors++;
        $error("FAIL %s ch0: got %0d want %0d", e.tag, count4[3:0], e.c0);
      end
      checks++;
      assert (count4[7:4] === 4'd0) else begin
        errors++;
        $error("FAIL %s ch1: got %0d want 0", e.tag, count4[7:4]);
      end
      checks++;
      assert (sat4 === e.sat) else begin
        errors++;
        $error("FAIL %s sat4: got %b want %b", e.tag, sat4, e.sat);
      end
    end
  endtask

  initial begin
    int dc0;
    exp4_t x;

    // reset with oscillators running
    for (int c = 0; c < NCH; c++) per[c] = c + 3;
    repeat (4) @(negedge clk);
    checks++;
    assert (busy === 1'b0 && done === 1'b0) else begin
      errors++;
      $error("FAIL reset_ctl: got busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    assert (count_out === '0) else begin
      errors++;
      $error("FAIL reset_count: got %h want 0", count_out);
    end
    checks++;
    assert (sat === '0) else begin
      errors++;
      $error("FAIL reset_sat: got %b want 0", sat);
    end
    rst = 1'b0;

    // idle with toggling inputs, no start
    repeat (50) @(negedge clk);
    checks++;
    assert (count_out === '0 && busy === 1'b0) else begin
      errors++;
      $error("FAIL idle: got count=%h busy=%b want 0 0", count_out, busy);
    end
    checks++;
    assert (done_cnt === 0) else begin
      errors++;
      $error("FAIL idle_done: got %0d pulses want 0", done_cnt);
    end

    // single channel, period 10, 1000-cycle window
    for (int c = 0; c < NCH; c++) per[c] = 0;
    per[0] = 10;
    repeat (100) @(negedge clk);
    push_exp("ch0_p10", 1000);
    measure(1000, 1'b0);

    // zero-length window
    push_exp("gate0", 0);
    measure(0, 1'b0);

    // start while busy must be ignored
    dc0 = done_cnt;
    push_exp("poke", 20);
    measure(20, 1'b1);
    repeat (30) @(negedge clk);
    checks++;
    assert (done_cnt === dc0 + 1) else begin
      errors++;
      $error("FAIL poke_done: got %0d pulses want 1", done_cnt - dc0);
    end

    // reset in the middle of a window
    @(negedge clk);
    start = 1'b1;
    gate_cycles = 20'd500;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    dc0 = done_cnt;
    rst = 1'b1;
    #1;
    checks++;
    assert (busy === 1'b0 && done === 1'b0 && count_out === '0) else begin
      errors++;
      $error("FAIL mid_rst: got busy=%b done=%b count=%h want 0 0 0",
             busy, done, count_out);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (600) @(negedge clk);
    checks++;
    assert (done_cnt === dc0) else begin
      errors++;
      $error("FAIL rst_no_done: got %0d pulses want 0", done_cnt - dc0);
    end
    per[0] = 4;
    repeat (50) @(negedge clk);
    push_exp("after_rst_p4", 200);
    measure(200, 1'b0);

    // all channels at distinct periods
    for (int c = 0; c < NCH; c++) per[c] = 4 + 2 * c;
    repeat (100) @(negedge clk);
    push_exp("all_ch", 2000);
    measure(2000, 1'b0);

    // narrow counter: 40 edges into a 4-bit counter
    x.tag = "cnt4_40";
`ifdef FREQ_METER_SAT_EN
    x.c0 = 4'd15;
    x.sat = 2'b01;
`else
    x.c0 = 4'd8;
    x.sat = 2'b00;
`endif
    q4.push_back(x);
    fork
      measure4(250);
      begin
        repeat (10) @(negedge clk);
        repeat (40) begin
          osc4[0] = 1'b1;
          repeat (2) @(negedge clk);
          osc4[0] = 1'b0;
          repeat (2) @(negedge clk);
        end
      end
    join
    x.tag = "cnt4_clear";
    x.c0 = 4'd0;
    x.sat = 2'b00;
    q4.push_back(x);
    repeat (2) @(negedge clk);
    measure4(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
